// File: rtl/ase_emul_ooo_resp_shuffle.sv
// Response shuffler for the ASE emulator: buffers responses in a small slot pool
// and releases them in LFSR-driven pseudo-random order with an age-based deadline.
module ase_emul_ooo_resp_shuffle #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned OUT_OF_ORDER = 1,
  parameter int unsigned MAX_AGE      = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hace1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic [DATA_WIDTH-1:0]          in_data,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned AGE_W = $clog2(MAX_AGE + 1);

  if (OUT_OF_ORDER == 0) begin : g_inorder

    always_ff @(posedge clk or posedge reset) begin
      if (reset) out_valid <= 1'b0;
      else       out_valid <= in_valid;
    end

    always_ff @(posedge clk) begin
      out_data <= in_data;
    end

    assign occupancy = '0;

  end else begin : g_shuffle

    logic [15:0]           lfsr;
    logic [DEPTH-1:0]      slot_valid;
    logic [DATA_WIDTH-1:0] slot_data [DEPTH];
    logic [AGE_W-1:0]      slot_age  [DEPTH];

    logic             aged_hit;
    logic [IDX_W-1:0] aged_idx;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] scan_start;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] probe;
    logic [IDX_W-1:0] victim;
    logic [IDX_W-1:0] wr_idx;
    logic             full;
    logic             emit;

    // Slot search: lowest expired slot, lowest free slot, and first valid slot from the random start
    always_comb begin
      aged_hit   = 1'b0;
      aged_idx   = '0;
      free_idx   = '0;
      scan_idx   = '0;
      probe      = '0;
      scan_start = lfsr[IDX_W:1];
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
        if (slot_valid[IDX_W'(i)] && slot_age[IDX_W'(i)] == AGE_W'(MAX_AGE)) begin
          aged_hit = 1'b1;
          aged_idx = IDX_W'(i);
        end
        if (!slot_valid[IDX_W'(i)]) free_idx = IDX_W'(i);
      end
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        probe = scan_start + IDX_W'(k);
        if (slot_valid[probe]) scan_idx = probe;
      end
    end

    // A full pool with a new arrival always releases one entry so nothing is dropped
    always_comb begin
      full   = (occupancy == OCC_W'(DEPTH));
      emit   = (occupancy != '0) && (aged_hit || (full && in_valid) || lfsr[0]);
      victim = aged_hit ? aged_idx : scan_idx;
      wr_idx = full ? victim : free_idx;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr <= LFSR_SEED;
      else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        slot_valid <= '0;
        for (int i = 0; i < int'(DEPTH); i++) slot_age[IDX_W'(i)] <= '0;
      end else begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (in_valid && wr_idx == IDX_W'(i)) begin
            slot_valid[IDX_W'(i)] <= 1'b1;
            slot_age[IDX_W'(i)]   <= '0;
          end else if (emit && victim == IDX_W'(i)) begin
            slot_valid[IDX_W'(i)] <= 1'b0;
            slot_age[IDX_W'(i)]   <= '0;
          end else if (slot_valid[IDX_W'(i)] && slot_age[IDX_W'(i)] != AGE_W'(MAX_AGE)) begin
            slot_age[IDX_W'(i)]   <= slot_age[IDX_W'(i)] + AGE_W'(1);
          end
        end
      end
    end

    // Payload storage carries no reset
    always_ff @(posedge clk) begin
      if (in_valid) slot_data[wr_idx] <= in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset)                  occupancy <= '0;
      else if (in_valid && !emit) occupancy <= occupancy + OCC_W'(1);
      else if (!in_valid && emit) occupancy <= occupancy - OCC_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) out_valid <= 1'b0;
      else       out_valid <= emit;
    end

    always_ff @(posedge clk) begin
      if (emit) out_data <= slot_data[victim];
    end

  end

endmodule

// File: tb/tb_ase_emul_ooo_resp_shuffle.sv
// Bench for the response shuffler: two shuffling instances with different seeds and
// one in-order instance, all checked cycle by cycle against a behavioural model.
module tb_ase_emul_ooo_resp_shuffle;

  localparam int unsigned DW      = 64;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned MAX_AGE = 8;
  localparam int unsigned OCC_W   = $clog2(DEPTH + 1);
  localparam logic [15:0] SEED_A  = 16'hace1;
  localparam logic [15:0] SEED_B  = 16'h5a5a;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          ov_a, ov_b, ov_p;
  logic [DW-1:0] od_a, od_b, od_p;
  logic [OCC_W-1:0] occ_a, occ_b, occ_p;

  ase_emul_ooo_resp_shuffle #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .OUT_OF_ORDER(1),
    .MAX_AGE(MAX_AGE), .LFSR_SEED(SEED_A)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov_a), .out_data(od_a), .occupancy(occ_a));

  ase_emul_ooo_resp_shuffle #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .OUT_OF_ORDER(1),
    .MAX_AGE(MAX_AGE), .LFSR_SEED(SEED_B)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov_b), .out_data(od_b), .occupancy(occ_b));

  ase_emul_ooo_resp_shuffle #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .OUT_OF_ORDER(0),
    .MAX_AGE(MAX_AGE), .LFSR_SEED(SEED_A)) dut_p (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov_p), .out_data(od_p), .occupancy(occ_p));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: a pool of slots per shuffling instance
  int unsigned   m_lfsr  [2];
  bit            m_valid [2][DEPTH];
  logic [DW-1:0] m_data  [2][DEPTH];
  int            m_age   [2][DEPTH];
  int            m_occ   [2];
  bit            m_ov    [2];
  logic [DW-1:0] m_od    [2];
  bit            m_known [2];
  bit            p_ov;
  logic [DW-1:0] p_od;
  bit            p_known;

  int            n_vec, n_err, cyc, dens, nm, nbad;
  int unsigned   seq;
  int            wcyc [logic [DW-1:0]];
  logic [DW-1:0] q_a[$], q_b[$], r1[$], r2[$], rb[$], srt[$], disc[$];
  bit            rec, differ, ooo;
  logic [DW-1:0] watch;
  int            watch_hits, disc_hits;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned lfsr_next(input int unsigned l);
    int unsigned fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l << 1) | fb) & 32'hffff;
  endfunction

  function automatic logic [DW-1:0] fresh();
    seq++;
    return {$urandom(), seq};
  endfunction

  task automatic model_reset(input int m);
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[m][i] = 1'b0;
      m_age[m][i]   = 0;
    end
    m_occ[m]  = 0;
    m_ov[m]   = 1'b0;
    m_lfsr[m] = (m == 0) ? 32'(SEED_A) : 32'(SEED_B);
  endtask

  // One clock of the pool: pick a release by the deadline/full/coin rules, then accept the arrival
  task automatic model_step(input int m, input bit iv, input logic [DW-1:0] id);
    int occ, aged, vic, start, wr;
    bit emit;
    occ = 0; aged = -1; vic = -1; wr = -1;
    for (int i = 0; i < DEPTH; i++)
      if (m_valid[m][i]) begin
        occ++;
        if (aged < 0 && m_age[m][i] == MAX_AGE) aged = i;
      end
    emit = (occ > 0) && (aged >= 0 || (occ == DEPTH && iv) || (m_lfsr[m] & 1) != 0);
    vic = aged;
    if (vic < 0) begin
      start = int'((m_lfsr[m] >> 1) % DEPTH);
      for (int k = 0; k < DEPTH; k++)
        if (vic < 0 && m_valid[m][(start + k) % DEPTH]) vic = (start + k) % DEPTH;
    end
    if (iv) begin
      if (occ == DEPTH) wr = vic;
      else for (int i = 0; i < DEPTH; i++) if (wr < 0 && !m_valid[m][i]) wr = i;
    end
    for (int i = 0; i < DEPTH; i++)
      if (m_valid[m][i] && m_age[m][i] < MAX_AGE) m_age[m][i]++;
    m_ov[m] = emit;
    if (emit) begin
      m_od[m] = m_data[m][vic];
      m_known[m] = 1'b1;
      m_valid[m][vic] = 1'b0;
    end
    if (wr >= 0) begin
      m_valid[m][wr] = 1'b1;
      m_data[m][wr]  = id;
      m_age[m][wr]   = 0;
    end
    m_occ[m] = occ + int'(iv) - int'(emit);
    m_lfsr[m] = lfsr_next(m_lfsr[m]);
  endtask

  task automatic compare();
    check_eq("ov_a", ov_a, m_ov[0]);
    check_eq("occ_a", occ_a, m_occ[0]);
    if (m_known[0]) check_eq("od_a", od_a, m_od[0]);
    check_eq("ov_b", ov_b, m_ov[1]);
    check_eq("occ_b", occ_b, m_occ[1]);
    if (m_known[1]) check_eq("od_b", od_b, m_od[1]);
    check_eq("ov_p", ov_p, p_ov);
    check_eq("occ_p", occ_p, 0);
    if (p_known) check_eq("od_p", od_p, p_od);
    if (ov_a === 1'b1) begin
      check_eq("sb_known", wcyc.exists(od_a), 1);
      if (wcyc.exists(od_a)) begin
        check_eq("latency", (cyc - wcyc[od_a] >= 1) && (cyc - wcyc[od_a] <= MAX_AGE + 1), 1);
        wcyc.delete(od_a);
      end
      if (rec) q_a.push_back(od_a);
      if (od_a === watch) watch_hits++;
      foreach (disc[i]) if (disc[i] === od_a) disc_hits++;
    end
    if (ov_b === 1'b1 && rec) q_b.push_back(od_b);
  endtask

  // Drive one cycle of input, advance the model, sample just after the edge
  task automatic tick(input bit iv, input logic [DW-1:0] id);
    in_valid = iv;
    in_data  = id;
    for (int m = 0; m < 2; m++) begin
      if (reset) model_reset(m);
      else       model_step(m, iv, id);
    end
    p_ov = reset ? 1'b0 : iv;
    p_od = id;
    p_known = 1'b1;
    cyc++;
    if (reset) wcyc.delete();
    else if (iv) wcyc[id] = cyc;
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) tick(1'b0, '0);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; seq = 0; rec = 1'b0;
    watch = 64'hdead_beef_0000_0000; watch_hits = 0; disc_hits = 0;
    for (int m = 0; m < 2; m++) begin
      m_known[m] = 1'b0;
      model_reset(m);
    end
    p_known = 1'b0;
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    #1;
    check_eq("rst_ov_a", ov_a, 0);
    check_eq("rst_occ_a", occ_a, 0);
    check_eq("rst_ov_p", ov_p, 0);

    // Inputs during reset are ignored
    repeat (3) tick(1'b1, fresh());
    reset = 1'b0;

    // In-order pass-through of 1,2,3
    tick(1'b1, 64'h1); tick(1'b1, 64'h2); tick(1'b1, 64'h3);
    repeat (MAX_AGE + 3) tick(1'b0, '0);
    check_eq("drain_inorder", occ_a, 0);
    check_eq("sb_empty_inorder", wcyc.num(), 0);

    // Lone entry must leave by its deadline
    watch = 64'haa; watch_hits = 0;
    tick(1'b1, 64'haa);
    repeat (MAX_AGE + 1) tick(1'b0, '0);
    check_eq("aa_once", watch_hits, 1);
    check_eq("aa_occ", occ_a, 0);

    // Arrival while full forces a same-cycle release
    for (int g = 0; g < 200 && occ_a != OCC_W'(DEPTH); g++) tick(1'b1, fresh());
    check_eq("fill_full", occ_a, DEPTH);
    watch = 64'h55; watch_hits = 0;
    tick(1'b1, 64'h55);
    check_eq("full_emit", ov_a, 1);
    check_eq("full_occ", occ_a, DEPTH);
    repeat (MAX_AGE + 4) tick(1'b0, '0);
    check_eq("x55_once", watch_hits, 1);
    check_eq("drain_full", wcyc.num(), 0);

    // Saturated stream, run twice from reset for repeatability
    for (int run = 0; run < 2; run++) begin
      pulse_reset();
      q_a.delete(); q_b.delete();
      rec = 1'b1;
      for (int i = 0; i < 1000; i++) tick(1'b1, 64'h2000 + 64'(i));
      repeat (MAX_AGE + 3) tick(1'b0, '0);
      rec = 1'b0;
      if (run == 0) begin r1 = q_a; rb = q_b; end
      else r2 = q_a;
    end
    check_eq("stream_count_a", r1.size(), 1000);
    check_eq("stream_count_b", rb.size(), 1000);
    check_eq("rerun_len", r2.size(), r1.size());
    nm = 0; differ = 1'b0; ooo = 1'b0;
    foreach (r1[i]) begin
      if (i < r2.size() && r1[i] !== r2[i]) nm++;
      if (i < rb.size() && r1[i] !== rb[i]) differ = 1'b1;
      if (i > 0 && r1[i] < r1[i-1]) ooo = 1'b1;
    end
    check_eq("same_seed_order", nm, 0);
    check_eq("diff_seed_order", differ, 1);
    check_eq("ooo_pair_seen", ooo, 1);
    srt = r1; srt.sort(); nbad = 0;
    foreach (srt[i]) if (srt[i] !== 64'h2000 + 64'(i)) nbad++;
    check_eq("each_once", nbad, 0);

    // Reset with three buffered responses discards them
    pulse_reset();
    for (int g = 0; g < 20 && occ_a != OCC_W'(3); g++) tick(1'b1, fresh());
    check_eq("occ_three", occ_a, 3);
    disc.delete();
    foreach (wcyc[k]) disc.push_back(k);
    check_eq("buffered_three", disc.size(), 3);
    reset = 1'b1;
    #1;
    check_eq("async_rst_ov", ov_a, 0);
    check_eq("async_rst_occ", occ_a, 0);
    repeat (2) tick(1'b0, '0);
    reset = 1'b0;
    disc_hits = 0;
    repeat (5) tick(1'b1, fresh());
    repeat (MAX_AGE + 4) tick(1'b0, '0);
    check_eq("discarded_absent", disc_hits, 0);
    disc.delete();

    // Random traffic with varying density
    for (int blk = 0; blk < 10; blk++) begin
      dens = int'($urandom_range(10, 100));
      for (int i = 0; i < 200; i++) begin
        if (int'($urandom_range(1, 100)) <= dens) tick(1'b1, fresh());
        else tick(1'b0, '0);
      end
    end
    repeat (MAX_AGE + 4) tick(1'b0, '0);
    check_eq("final_drain", wcyc.num(), 0);
    check_eq("final_occ", occ_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
